// File: rtl/loop_track_sequencer_pkg.sv
// loop_track_sequencer_pkg
//   Shared sizes, the rest code and FSM state encodings for the 8-track
//   step looper.
//   Ports: none (package).
package loop_track_sequencer_pkg;

    localparam int NUM_TRACKS = 8;
    localparam int STEPS      = 128;
    localparam int STEP_W     = 7;
    localparam int NOTE_W     = 8;

    localparam logic [NOTE_W-1:0] NOTE_REST = 8'h00;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/loop_track_sequencer_if.sv
// loop_track_sequencer_if
//   Bundles the looper's key/track/step inputs and note/busy outputs.
//   Signals:
//     dataIn       live key code, 0 = no key
//     trackChooser per-track record arm bits
//     trackCount   step index supplied by the external step counter
//     notesOut     one NOTE_W lane per track, lane t at [t*NOTE_W +: NOTE_W]
//     busy         high while the track memories are being cleared
//   Modports: master drives the inputs, slave is the looper itself.
interface loop_track_sequencer_if;
    import loop_track_sequencer_pkg::*;

    logic [NOTE_W-1:0]            dataIn;
    logic [NUM_TRACKS-1:0]        trackChooser;
    logic [STEP_W-1:0]            trackCount;
    logic [NUM_TRACKS*NOTE_W-1:0] notesOut;
    logic                         busy;

    modport master (
        output dataIn,
        output trackChooser,
        output trackCount,
        input  notesOut,
        input  busy
    );

    modport slave (
        input  dataIn,
        input  trackChooser,
        input  trackCount,
        output notesOut,
        output busy
    );

endinterface

// File: rtl/loop_track_sequencer_ram.sv
// loop_track_ram
//   One track's note memory: STEPS x NOTE_W, synchronous write, asynchronous
//   read, single write port.
//   Ports:
//     rateClock  in  step clock
//     we         in  write enable
//     waddr      in  write address
//     wdata      in  write data
//     raddr      in  read address
//     rdata      out note stored at raddr (combinational)
module loop_track_ram
    import loop_track_sequencer_pkg::*;
(
    input  logic              rateClock,
    input  logic              we,
    input  logic [STEP_W-1:0] waddr,
    input  logic [NOTE_W-1:0] wdata,
    input  logic [STEP_W-1:0] raddr,
    output logic [NOTE_W-1:0] rdata
);

    logic [NOTE_W-1:0] mem [STEPS];

    always_ff @(posedge rateClock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/loop_track_sequencer.sv
// loop_track_sequencer
//   8-track, 128-step note looper. After reset every track memory is swept to
//   the rest code (busy high), then armed tracks overdub the live key code into
//   the step given by trackCount while every track plays its stored note for
//   that step on its own output lane, one rateClock edge later.
//   Ports:
//     rateClock  in  step clock (one edge per loop step)
//     reset      in  synchronous, active-low
//     bus        loop_track_sequencer_if.slave (dataIn, trackChooser,
//                trackCount in; notesOut, busy out)
module loop_track_sequencer
    import loop_track_sequencer_pkg::*;
(
    input  logic                         rateClock,
    input  logic                         reset,
    loop_track_sequencer_if.slave        bus
);

    state_t                       state;
    logic [STEP_W-1:0]            clr_addr;
    logic [NUM_TRACKS*NOTE_W-1:0] notes_q;
    logic                         busy_q;

    logic                         key_down;
    logic [STEP_W-1:0]            wr_addr;
    logic [NOTE_W-1:0]            wr_data;
    logic [NUM_TRACKS-1:0]        wr_en;
    logic [NOTE_W-1:0]            rd_data [NUM_TRACKS];
    logic [NUM_TRACKS*NOTE_W-1:0] next_notes;

    assign key_down = (bus.dataIn != NOTE_REST);

    // Memory port control. The reset edge itself writes nothing; the sweep
    // begins on the first edge after reset is released.
    always_comb begin
        wr_addr = (state == ST_CLEAR) ? clr_addr  : bus.trackCount;
        wr_data = (state == ST_CLEAR) ? NOTE_REST : bus.dataIn;
        wr_en   = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            wr_en[t] = reset && ((state == ST_CLEAR) ||
                                 (bus.trackChooser[t] && key_down));
        end
    end

    for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_track
        loop_track_ram u_ram (
            .rateClock (rateClock),
            .we        (wr_en[g]),
            .waddr     (wr_addr),
            .wdata     (wr_data),
            .raddr     (bus.trackCount),
            .rdata     (rd_data[g])
        );
    end

    // Write-first lane mux: a track being recorded monitors the live key
    // rather than the (old) stored note.
    always_comb begin
        next_notes = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            next_notes[t*NOTE_W +: NOTE_W] =
                (bus.trackChooser[t] && key_down) ? bus.dataIn : rd_data[t];
        end
    end

    always_ff @(posedge rateClock) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            notes_q  <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    notes_q  <= '0;
                    if (clr_addr == STEP_W'(STEPS - 1)) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    notes_q <= next_notes;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.notesOut = notes_q;
    assign bus.busy     = busy_q;

endmodule
